// File: rtl/rom_arbiter_nport.sv
// ---------------------------------------------------------------------------
// rom_arbiter_nport
//
// Shared table ROM for the PicBlaze multiprocessor system. NCH processors
// read a single-ported synchronous ROM through a req/ack handshake. A
// round-robin arbiter grants one read per clock. Channel k addresses its own
// window of the table starting at k*BASE_STRIDE. Each channel's read data is
// registered and held until that channel's next read returns.
//
// Optional feature macro: ROM_RANGE_CHECK_EN
//   defined   : err[k] pulses with valid[k] for out-of-range reads, and
//               elaboration fails if the last window starts past the ROM.
//   undefined : err is tied to 0; out-of-range reads silently return 0.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [NCH]         per-channel read request (level)
//   addr   in   [NCH*ADDR_W]  per-channel address, channel k at [k*ADDR_W +: ADDR_W]
//   ack    out  [NCH]         grant; request/address captured this cycle
//   valid  out  [NCH]         one-cycle pulse; data slice updated this cycle
//   data   out  [NCH*DATA_W]  per-channel read data, held between valids
//   err    out  [NCH]         out-of-range flag, coincident with valid
//
// Latency: ack in cycle T -> valid/data in cycle T+2. No stalls.
// ---------------------------------------------------------------------------
module rom_arbiter_nport #(
  parameter int    DATA_W      = 8,
  parameter int    ADDR_W      = 8,
  parameter int    DEPTH       = 200,
  parameter int    NCH         = 2,
  parameter int    BASE_STRIDE = 100,
  parameter string INIT_FILE   = ""
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*ADDR_W-1:0]    addr,
  output logic [NCH-1:0]           ack,
  output logic [NCH-1:0]           valid,
  output logic [NCH*DATA_W-1:0]    data,
  output logic [NCH-1:0]           err
);

  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Physical address is formed at full 32-bit width so that a window plus
  // offset running past DEPTH is detected rather than wrapped.
  function automatic logic [31:0] phys_addr(input logic [PTR_W-1:0] ch,
                                            input logic [ADDR_W-1:0] a);
    return (32'(ch) * 32'(BASE_STRIDE)) + 32'(a);
  endfunction

  // Returns ROM word or zero when the read fell outside the table.
  function automatic logic [DATA_W-1:0] range_gate(input logic            in_range,
                                                   input logic [DATA_W-1:0] word);
    return in_range ? word : '0;
  endfunction

  // Arbiter state
  logic [PTR_W-1:0]      r_ptr;

  // Grant decode
  logic                  w_gnt_any;
  logic [PTR_W-1:0]      w_gnt_ch;
  logic [PTR_W-1:0]      w_cand;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [31:0]           w_pa;
  logic                  w_inr;

  // Stage S0 -> S1 registers
  logic                  r_vld_p0;
  logic [PTR_W-1:0]      r_ch_p0;
  logic [RA_W-1:0]       r_pa_p0;
  logic                  r_inr_p0;

  // ROM read port
  logic [DATA_W-1:0]     w_rom_rd;

  // Output registers
  logic [NCH-1:0]        r_valid;
  logic [NCH*DATA_W-1:0] r_data;

  // -------------------------------------------------------------------------
  // S0: round-robin grant
  // -------------------------------------------------------------------------
  // Scan from the highest offset down so that the last hit, which wins, is
  // the nearest requester at or above the pointer.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_ch  = '0;
    w_cand    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      w_cand = PTR_W'((int'(r_ptr) + i) % NCH);
      if (req[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_ch  = w_cand;
      end
    end
  end

  assign w_sel_addr = addr[int'(w_gnt_ch) * ADDR_W +: ADDR_W];
  assign w_pa       = phys_addr(w_gnt_ch, w_sel_addr);
  assign w_inr      = (w_pa < 32'(DEPTH));

  assign ack = w_gnt_any ? (NCH'(1) << w_gnt_ch) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_gnt_any;
      if (w_gnt_any) begin
        r_ptr <= (int'(w_gnt_ch) == NCH - 1) ? '0 : w_gnt_ch + 1'b1;
      end
    end
  end

  // Address, channel and range flag only matter while r_vld_p0 is set.
  always_ff @(posedge clk) begin
    r_ch_p0  <= w_gnt_ch;
    r_pa_p0  <= w_pa[RA_W-1:0];
    r_inr_p0 <= w_inr;
  end

  // -------------------------------------------------------------------------
  // S1: synchronous ROM read, landing directly in the granted channel's
  // data register so the result is visible (S2) two cycles after ack.
  // -------------------------------------------------------------------------
  // Contents: word i holds i truncated to the data width.
  assign w_rom_rd = DATA_W'(r_pa_p0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= '0;
      if (r_vld_p0) begin
        r_valid[r_ch_p0]                         <= 1'b1;
        r_data[int'(r_ch_p0) * DATA_W +: DATA_W] <= range_gate(r_inr_p0, w_rom_rd);
      end
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

`ifdef ROM_RANGE_CHECK_EN
  logic [NCH-1:0] r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      r_err <= '0;
      if (r_vld_p0) begin
        r_err[r_ch_p0] <= ~r_inr_p0;
      end
    end
  end

  assign err = r_err;

  // The last channel's window must start inside the table.
  generate
    if ((NCH - 1) * BASE_STRIDE >= DEPTH) begin : g_bad_layout
      $error("rom_arbiter_nport: (NCH-1)*BASE_STRIDE must be below DEPTH");
    end
  endgenerate
`else
  assign err = '0;
`endif

endmodule
